// File: rtl/modinv_helper_cmp_pkg.sv
// Shared constants, flag bundle and width helper for the modinv compare helper.
// The compare block is one of the stages the inverter loop runs on every iteration.
package modinv_helper_cmp_pkg;

    localparam int DEFAULT_NUM_WORDS = 9;
    localparam int DEFAULT_ADDR_BITS = 4;
    localparam int WORD_BITS         = 32;

    // Field order is the bit order the flags use throughout the helper family.
    typedef struct packed {
        logic gt;
        logic eq;
        logic u_even;
        logic v_even;
        logic v_eq_one;
    } cmp_flags_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/modinv_helper_cmp_if.sv
// Start/done handshake, buffer read port and result flags of the compare helper.
// The loop FSM side uses master; the compare helper uses slave.
interface modinv_helper_cmp_if
    import modinv_helper_cmp_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) ();

    logic                 ena;
    logic                 rdy;
    logic [ADDR_BITS-1:0] u_addr;
    logic [ADDR_BITS-1:0] v_addr;
    logic [WORD_BITS-1:0] u_din;
    logic [WORD_BITS-1:0] v_din;
    logic                 u_gt_v;
    logic                 u_eq_v;
    logic                 u_even;
    logic                 v_even;
    logic                 v_eq_one;

    modport master (
        output ena, u_din, v_din,
        input  rdy, u_addr, v_addr, u_gt_v, u_eq_v, u_even, v_even, v_eq_one
    );

    modport slave (
        input  ena, u_din, v_din,
        output rdy, u_addr, v_addr, u_gt_v, u_eq_v, u_even, v_even, v_eq_one
    );

endinterface

// File: rtl/modinv_helper_cmp_word.sv
// Unsigned compare of one u/v buffer word pair; exactly one output is high.
module modinv_helper_cmp_word
    import modinv_helper_cmp_pkg::*;
(
    input  logic [WORD_BITS-1:0] a_i,
    input  logic [WORD_BITS-1:0] b_i,
    output logic                 gt_o,
    output logic                 lt_o,
    output logic                 eq_o
);

    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);
    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/modinv_helper_cmp.sv
// Scans the u/v buffers from word 0 upward and publishes registered comparison and
// parity flags once per start pulse; the buffers are only read, never written.
module modinv_helper_cmp
    import modinv_helper_cmp_pkg::*;
#(
    parameter int BUFFER_NUM_WORDS = DEFAULT_NUM_WORDS,
    parameter int BUFFER_ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    modinv_helper_cmp_if.slave  bus
);

    localparam int PROC_NUM_CYCLES = BUFFER_NUM_WORDS + 3;
    localparam int CNT_W           = clog2(PROC_NUM_CYCLES);

    // Address runs one count ahead of the data window because of the 1-cycle read latency.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PROC_NUM_CYCLES - 1);
    localparam logic [CNT_W-1:0] ADDR_START = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_STOP  = CNT_W'(BUFFER_NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] ACC_START  = CNT_W'(2);
    localparam logic [CNT_W-1:0] ACC_STOP   = CNT_W'(BUFFER_NUM_WORDS + 1);

    logic [CNT_W-1:0]            proc_cnt_q, proc_cnt_d;
    logic [BUFFER_ADDR_BITS-1:0] addr_q, addr_d;
    logic                        gt_acc_q, gt_acc_d;
    logic                        eq_acc_q, eq_acc_d;
    logic                        one_acc_q, one_acc_d;
    logic                        u_even_acc_q, u_even_acc_d;
    logic                        v_even_acc_q, v_even_acc_d;
    cmp_flags_t                  flags_q, flags_d;

    logic rdy;
    logic advance;
    logic addr_run;
    logic acc_run;
    logic first_word;
    logic last_word;
    logic word_gt;
    logic word_lt;
    logic word_eq;

    modinv_helper_cmp_word u_word (
        .a_i  (bus.u_din),
        .b_i  (bus.v_din),
        .gt_o (word_gt),
        .lt_o (word_lt),
        .eq_o (word_eq)
    );

    always_comb begin
        rdy        = (proc_cnt_q == '0);
        advance    = !rdy || bus.ena;
        addr_run   = (proc_cnt_q >= ADDR_START) && (proc_cnt_q <= ADDR_STOP);
        acc_run    = (proc_cnt_q >= ACC_START) && (proc_cnt_q <= ACC_STOP);
        first_word = (proc_cnt_q == ACC_START);
        last_word  = (proc_cnt_q == ACC_STOP);

        proc_cnt_d = proc_cnt_q;
        if (advance) begin
            proc_cnt_d = (proc_cnt_q == CNT_LAST) ? '0 : proc_cnt_q + 1'b1;
        end

        addr_d = addr_run ? addr_q + 1'b1 : '0;
    end

    // Words arrive least significant first, so a later difference overrides an earlier one.
    always_comb begin
        gt_acc_d     = gt_acc_q;
        eq_acc_d     = eq_acc_q;
        one_acc_d    = one_acc_q;
        u_even_acc_d = u_even_acc_q;
        v_even_acc_d = v_even_acc_q;
        if (acc_run) begin
            if (first_word) begin
                gt_acc_d     = word_gt;
                eq_acc_d     = word_eq;
                one_acc_d    = (bus.v_din == WORD_BITS'(1));
                u_even_acc_d = ~bus.u_din[0];
                v_even_acc_d = ~bus.v_din[0];
            end else begin
                if (word_gt) begin
                    gt_acc_d = 1'b1;
                end else if (word_lt) begin
                    gt_acc_d = 1'b0;
                end
                eq_acc_d  = eq_acc_q & word_eq;
                one_acc_d = one_acc_q & (bus.v_din == '0);
            end
        end

        flags_d = flags_q;
        if (last_word) begin
            flags_d.gt       = gt_acc_d;
            flags_d.eq       = eq_acc_d;
            flags_d.u_even   = u_even_acc_d;
            flags_d.v_even   = v_even_acc_d;
            flags_d.v_eq_one = one_acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proc_cnt_q <= '0;
            flags_q    <= '0;
        end else begin
            proc_cnt_q <= proc_cnt_d;
            flags_q    <= flags_d;
        end
    end

    // Address and accumulators are rebuilt from scratch by every scan, so they carry no reset.
    always_ff @(posedge clk) begin
        addr_q       <= addr_d;
        gt_acc_q     <= gt_acc_d;
        eq_acc_q     <= eq_acc_d;
        one_acc_q    <= one_acc_d;
        u_even_acc_q <= u_even_acc_d;
        v_even_acc_q <= v_even_acc_d;
    end

    assign bus.rdy      = rdy;
    assign bus.u_addr   = addr_q;
    assign bus.v_addr   = addr_q;
    assign bus.u_gt_v   = flags_q.gt;
    assign bus.u_eq_v   = flags_q.eq;
    assign bus.u_even   = flags_q.u_even;
    assign bus.v_even   = flags_q.v_even;
    assign bus.v_eq_one = flags_q.v_eq_one;

endmodule
